// File: rtl/alu_sequencer.sv
// Multi-cycle add/sub/shift-add multiply/restoring divide controller with busy/done handshake.
// Optional LED hold output for ovf/err completions is enabled by defining ALU_SEQ_LED_EN.
module alu_sequencer #(
    parameter int unsigned WIDTH = 4
`ifdef ALU_SEQ_LED_EN
    ,
    parameter int unsigned LED_HOLD = 8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [1:0]         sel,
    output logic [2*WIDTH-1:0] out,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic               err
`ifdef ALU_SEQ_LED_EN
    ,
    output logic               led
`endif
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_e;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;

    state_e               state_q, state_d;
    op_e                  sel_q, sel_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     x_q, x_d, y_q, y_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d;
    logic [2*WIDTH-1:0]   out_q, out_d;
    logic                 busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, err_q, err_d;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     rem_step, quo_step;
    logic                 finish;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        out_d    = out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        err_d    = err_q;
        finish   = 1'b0;

        sum      = {1'b0, x_q} + {1'b0, y_q};
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        // Remainder is kept W bits wide (always < divisor); the shifted trial value carries the extra bit.
        trial    = {rem_q, quo_q[WIDTH-1]};
        if (trial >= {1'b0, y_q}) begin
            rem_step = trial[WIDTH-1:0] - y_q;
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d      = x;
                    y_d      = y;
                    sel_d    = op_e'(sel);
                    mcand_d  = {{WIDTH{1'b0}}, x};
                    mplier_d = y;
                    acc_d    = '0;
                    rem_d    = '0;
                    quo_d    = x;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                unique case (sel_q)
                    OP_ADD: begin
                        out_d  = {{(WIDTH-1){1'b0}}, sum};
                        ovf_d  = sum[WIDTH];
                        finish = 1'b1;
                    end
                    OP_SUB: begin
                        out_d  = {{WIDTH{1'b0}}, x_q - y_q};
                        ovf_d  = (x_q < y_q);
                        finish = 1'b1;
                    end
                    OP_MUL: begin
                        acc_d    = acc_step;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        cnt_d    = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            out_d  = acc_step;
                            finish = 1'b1;
                        end
                    end
                    OP_DIV: begin
                        if (y_q == '0) begin
                            out_d  = '1;
                            err_d  = 1'b1;
                            finish = 1'b1;
                        end else begin
                            rem_d = rem_step;
                            quo_d = quo_step;
                            cnt_d = cnt_q + 1'b1;
                            if (cnt_q == LAST_CNT) begin
                                out_d  = {rem_step, quo_step};
                                finish = 1'b1;
                            end
                        end
                    end
                    default: finish = 1'b1;
                endcase
                if (finish) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= OP_ADD;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign err  = err_q;

`ifdef ALU_SEQ_LED_EN
    localparam int unsigned LW = $clog2(LED_HOLD + 1);

    logic [LW-1:0] led_cnt_q;
    logic          led_q;

    // led rises together with done; the counter tracks the remaining high cycles after the first.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_cnt_q <= '0;
            led_q     <= 1'b0;
        end else if (done_d && (ovf_d || err_d)) begin
            led_cnt_q <= LW'(LED_HOLD - 1);
            led_q     <= 1'b1;
        end else if (led_cnt_q != '0) begin
            led_cnt_q <= led_cnt_q - 1'b1;
            led_q     <= 1'b1;
        end else begin
            led_q     <= 1'b0;
        end
    end

    assign led = led_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer (WIDTH=4); LED checks compile only with ALU_SEQ_LED_EN.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] x, y;
    logic [1:0] sel;
    logic [7:0] out;
    logic       busy, done, ovf, err;
`ifdef ALU_SEQ_LED_EN
    logic       led;
`endif

    int checks   = 0;
    int failures = 0;

    alu_sequencer #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .sel   (sel),
        .out   (out),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .err   (err)
`ifdef ALU_SEQ_LED_EN
        ,
        .led   (led)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] s;
        logic [7:0] eo;
        logic       eovf;
        logic       eerr;
        int         lat;
    } vec_t;

    vec_t vecs[$] = '{
        '{4'd9,  4'd8,  2'b00, 8'h11, 1'b1, 1'b0, 1},
        '{4'd3,  4'd5,  2'b01, 8'h0E, 1'b1, 1'b0, 1},
        '{4'd7,  4'd7,  2'b01, 8'h00, 1'b0, 1'b0, 1},
        '{4'd15, 4'd15, 2'b00, 8'h1E, 1'b1, 1'b0, 1},
        '{4'd15, 4'd15, 2'b10, 8'hE1, 1'b0, 1'b0, 4},
        '{4'd0,  4'd9,  2'b10, 8'h00, 1'b0, 1'b0, 4},
        '{4'd15, 4'd3,  2'b10, 8'h2D, 1'b0, 1'b0, 4},
        '{4'd13, 4'd4,  2'b11, 8'h13, 1'b0, 1'b0, 4},
        '{4'd7,  4'd0,  2'b11, 8'hFF, 1'b0, 1'b1, 1},
        '{4'd15, 4'd1,  2'b11, 8'h0F, 1'b0, 1'b0, 4},
        '{4'd5,  4'd7,  2'b11, 8'h50, 1'b0, 1'b0, 4},
        '{4'd2,  4'd2,  2'b00, 8'h04, 1'b0, 1'b0, 1}
    };

    // Starts one op, disturbs start/operands while busy, and checks latency, result and pulse width.
    task automatic run_op(input vec_t v);
        logic [7:0] prev;
        int n;
        prev  = out;
        x     = v.a;
        y     = v.b;
        sel   = v.s;
        start = 1'b1;
        step();
        check_eq("e0_busy", busy, 1);
        check_eq("e0_done", done, 0);
        check_eq("e0_out_hold", out, prev);
        check_eq("e0_ovf_clr", ovf, 0);
        check_eq("e0_err_clr", err, 0);
        x     = ~v.a;
        y     = ~v.b;
        sel   = ~v.s;
        n     = 0;
        while (done !== 1'b1 && n < 20) begin
            step();
            start = 1'b0;
            n++;
        end
        start = 1'b0;
        check_eq("latency", n, v.lat);
        check_eq("out", out, v.eo);
        check_eq("ovf", ovf, v.eovf);
        check_eq("err", err, v.eerr);
        check_eq("busy_at_done", busy, 0);
        step();
        check_eq("done_one_cycle", done, 0);
        check_eq("out_hold", out, v.eo);
        check_eq("ovf_hold", ovf, v.eovf);
    endtask

    initial begin
        int n;
        int dones;
        rst   = 1'b1;
        start = 1'(($urandom));
        x     = 4'($urandom);
        y     = 4'($urandom);
        sel   = 2'($urandom);
        step();
        step();
        check_eq("rst_out", out, 8'h00);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_err", err, 0);
        rst   = 1'b0;
        start = 1'b0;
        step();

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset during the second RUN cycle of a multiply.
        x = 4'd3; y = 4'd5; sel = 2'b10; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_out", out, 8'h00);
        check_eq("midrst_done", done, 0);
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (done === 1'b1) dones++;
        end
        check_eq("midrst_no_done", dones, 0);

        // Back-to-back: second start during the done cycle.
        x = 4'd2; y = 4'd3; sel = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_eq("b2b_done1", done, 1);
        check_eq("b2b_out1", out, 8'h05);
        x = 4'd6; y = 4'd7; sel = 2'b10; start = 1'b1;
        step();
        start = 1'b0;
        check_eq("b2b_accept_busy", busy, 1);
        check_eq("b2b_accept_done", done, 0);
        check_eq("b2b_out_hold", out, 8'h05);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_eq("b2b_latency", n, 4);
        check_eq("b2b_out2", out, 8'h2A);
        step();

`ifdef ALU_SEQ_LED_EN
        // 9+8 sets ovf: led high for 8 cycles starting with the done cycle.
        x = 4'd9; y = 4'd8; sel = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_eq("led_rise", led, 1);
        n = 0;
        while (led === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check_eq("led_hold", n, 8);

        // Divide-by-zero finishing at hold cycle 5 restarts the count.
        x = 4'd9; y = 4'd8; sel = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        x = 4'd7; y = 4'd0; sel = 2'b11; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_eq("led_dz_done", done, 1);
        n = 0;
        while (led === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check_eq("led_restart", n, 8);

        // 2+2 does not qualify.
        x = 4'd2; y = 4'd2; sel = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_eq("led_quiet_done", done, 1);
        check_eq("led_quiet", led, 0);
        step();
        check_eq("led_quiet_after", led, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
